// File: rtl/alu_pkg.sv
// alu shared definitions: widths, RV32I opcodes,
// funct3 codes and the queued result record.
package alu_pkg;

  localparam int DATA_WID = 32;
  localparam int ROB_WID  = 4;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef struct packed {
    logic [ROB_WID-1:0]  rob_pos;
    logic [DATA_WID-1:0] val;
    logic                jump;
    logic [DATA_WID-1:0] target;
  } res_t;

endpackage

// File: rtl/alu_if.sv
// alu issue and CDB signals; master is the
// reservation station / arbiter side, slave the alu.
interface alu_if;
  import alu_pkg::*;

  logic                alu_rdy;
  logic                alu_en;
  logic [6:0]          alu_opcode;
  logic [2:0]          alu_funct3;
  logic                alu_funct7;
  logic [DATA_WID-1:0] alu_val1;
  logic [DATA_WID-1:0] alu_val2;
  logic [DATA_WID-1:0] alu_imm;
  logic [DATA_WID-1:0] alu_pc;
  logic [ROB_WID-1:0]  alu_rob_pos;
  logic                cdb_req;
  logic                cdb_grant;
  logic [ROB_WID-1:0]  cdb_rob_pos;
  logic [DATA_WID-1:0] cdb_val;
  logic                cdb_jump;
  logic [DATA_WID-1:0] cdb_target;

  modport master (
    input  alu_rdy, cdb_req, cdb_rob_pos,
    input  cdb_val, cdb_jump, cdb_target,
    output alu_en, alu_opcode, alu_funct3,
    output alu_funct7, alu_val1, alu_val2,
    output alu_imm, alu_pc, alu_rob_pos,
    output cdb_grant
  );

  modport slave (
    output alu_rdy, cdb_req, cdb_rob_pos,
    output cdb_val, cdb_jump, cdb_target,
    input  alu_en, alu_opcode, alu_funct3,
    input  alu_funct7, alu_val1, alu_val2,
    input  alu_imm, alu_pc, alu_rob_pos,
    input  cdb_grant
  );

endinterface

// File: rtl/alu_core.sv
// alu_core: combinational RV32I integer compute.
// ALU_BRANCH_EN adds BRANCH/JAL/JALR outcomes.
module alu_core
  import alu_pkg::*;
(
  input  logic [6:0]          opcode,
  input  logic [2:0]          funct3,
  input  logic                funct7,
  input  logic [DATA_WID-1:0] val1,
  input  logic [DATA_WID-1:0] val2,
  input  logic [DATA_WID-1:0] imm,
  input  logic [DATA_WID-1:0] pc,
  output logic [DATA_WID-1:0] val,
  output logic                jump,
  output logic [DATA_WID-1:0] target
);

  logic                is_op;
  logic                is_imm;
  logic                is_lui;
  logic                is_auipc;
  logic [DATA_WID-1:0] opb;
  logic [4:0]          sh;
  logic [DATA_WID-1:0] alu_out;

  assign is_op    = opcode == OPC_OP;
  assign is_imm   = opcode == OPC_OP_IMM;
  assign is_lui   = opcode == OPC_LUI;
  assign is_auipc = opcode == OPC_AUIPC;
  assign opb      = is_op ? val2 : imm;
  assign sh       = opb[4:0];

  // shared OP / OP-IMM datapath; SUB only exists in OP
  always_comb begin
    alu_out = '0;
    unique case (funct3)
      F3_ADD: begin
        if (is_op && funct7) alu_out = val1 - opb;
        else alu_out = val1 + opb;
      end
      F3_SLL:  alu_out = val1 << sh;
      F3_SLT:  alu_out = {{(DATA_WID-1){1'b0}},
                          $signed(val1) < $signed(opb)};
      F3_SLTU: alu_out = {{(DATA_WID-1){1'b0}},
                          val1 < opb};
      F3_XOR:  alu_out = val1 ^ opb;
      F3_SR: begin
        if (funct7) alu_out = $signed(val1) >>> sh;
        else alu_out = val1 >> sh;
      end
      F3_OR:   alu_out = val1 | opb;
      F3_AND:  alu_out = val1 & opb;
    endcase
  end

`ifdef ALU_BRANCH_EN
  logic                is_br;
  logic                is_jal;
  logic                is_jalr;
  logic                taken;
  logic [DATA_WID-1:0] jr_sum;

  assign is_br   = opcode == OPC_BRANCH;
  assign is_jal  = opcode == OPC_JAL;
  assign is_jalr = opcode == OPC_JALR;
  assign jr_sum  = val1 + imm;

  // branch condition from funct3; reserved codes never taken
  always_comb begin
    taken = 1'b0;
    unique case (funct3)
      F3_BEQ:  taken = val1 == val2;
      F3_BNE:  taken = val1 != val2;
      F3_BLT:  taken = $signed(val1) < $signed(val2);
      F3_BGE:  taken = $signed(val1) >= $signed(val2);
      F3_BLTU: taken = val1 < val2;
      F3_BGEU: taken = val1 >= val2;
      default: taken = 1'b0;
    endcase
  end
`endif

  // result select by opcode class; unknown opcodes give zeros
  always_comb begin
    val    = '0;
    jump   = 1'b0;
    target = '0;
    unique case (1'b1)
      is_op, is_imm: val = alu_out;
      is_lui:        val = imm;
      is_auipc:      val = pc + imm;
`ifdef ALU_BRANCH_EN
      is_br: begin
        jump   = taken;
        target = pc + imm;
      end
      is_jal: begin
        val    = pc + DATA_WID'(4);
        jump   = 1'b1;
        target = pc + imm;
      end
      is_jalr: begin
        val    = pc + DATA_WID'(4);
        jump   = 1'b1;
        target = {jr_sum[DATA_WID-1:1], 1'b0};
      end
`endif
      default: ;
    endcase
  end

endmodule

// File: rtl/alu.sv
// alu: issue -> compute -> 2-entry result queue -> CDB.
// Optional branch/jump support under ALU_BRANCH_EN.
module alu
  import alu_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic rdy,
  input  logic rollback,
  alu_if.slave bus
);

  res_t                q [2];
  logic                head;
  logic                tail;
  logic [1:0]          count;
  logic                enq;
  logic                deq;
  logic                can_issue;
  logic                has_head;
  res_t                new_e;
  logic [DATA_WID-1:0] c_val;
  logic                c_jump;
  logic [DATA_WID-1:0] c_target;

  alu_core u_core (
    .opcode (bus.alu_opcode),
    .funct3 (bus.alu_funct3),
    .funct7 (bus.alu_funct7),
    .val1   (bus.alu_val1),
    .val2   (bus.alu_val2),
    .imm    (bus.alu_imm),
    .pc     (bus.alu_pc),
    .val    (c_val),
    .jump   (c_jump),
    .target (c_target)
  );

  assign can_issue = count != 2'd2;
  assign has_head  = count != 2'd0;
  assign enq = rdy & bus.alu_en & can_issue & ~rollback;
  assign deq = rdy & has_head & bus.cdb_grant & ~rollback;

  assign new_e.rob_pos = bus.alu_rob_pos;
  assign new_e.val     = c_val;
  assign new_e.jump    = c_jump;
  assign new_e.target  = c_target;

  // circular queue: flush on rollback, else enqueue/dequeue
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q[0]  <= '0;
      q[1]  <= '0;
      head  <= 1'b0;
      tail  <= 1'b0;
      count <= 2'd0;
    end else if (rdy && rollback) begin
      head  <= 1'b0;
      tail  <= 1'b0;
      count <= 2'd0;
    end else begin
      if (enq) begin
        q[tail] <= new_e;
        tail    <= ~tail;
      end
      if (deq) head <= ~head;
      count <= count + {1'b0, enq} - {1'b0, deq};
    end
  end

  assign bus.alu_rdy     = can_issue;
  assign bus.cdb_req     = has_head;
  assign bus.cdb_rob_pos = q[head].rob_pos;
  assign bus.cdb_val     = q[head].val;
  assign bus.cdb_jump    = q[head].jump;
  assign bus.cdb_target  = q[head].target;

endmodule

// File: tb/tb_alu.sv
// tb_alu: directed vector table, hand sequences for
// queue corner cases, and randomized scoreboard run.
module tb_alu;
  import alu_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rdy = 1'b0;
  logic rollback = 1'b0;

  alu_if bus ();

  alu dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rdy      (rdy),
    .rollback (rollback),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [6:0]  op;
    logic [2:0]  f3;
    logic        f7;
    logic [31:0] v1;
    logic [31:0] v2;
    logic [31:0] imm;
    logic [31:0] pc;
    logic [3:0]  tag;
    logic [31:0] ev;
    logic        ej;
    logic [31:0] et;
  } vec_t;

  vec_t tbl[$];
  res_t mq[$];

  task automatic chk(string name, logic [31:0] act,
                     logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(
    logic [6:0] op, logic [2:0] f3, logic f7,
    logic [31:0] v1, logic [31:0] v2,
    logic [31:0] imm, logic [31:0] pc, logic [3:0] tag,
    logic [31:0] ev, logic ej, logic [31:0] et);
    vec_t v;
    v.op = op; v.f3 = f3; v.f7 = f7;
    v.v1 = v1; v.v2 = v2; v.imm = imm; v.pc = pc;
    v.tag = tag; v.ev = ev; v.ej = ej; v.et = et;
    return v;
  endfunction

  // reference: RV32I semantics written from the ISA rules
  function automatic res_t model(
    logic [6:0] op, logic [2:0] f3, logic f7,
    logic [31:0] a, logic [31:0] r2,
    logic [31:0] imm, logic [31:0] pc);
    res_t r;
    logic [31:0] b;
    int sa;
    int sb;
    r = '0;
    b = (op == 7'h33) ? r2 : imm;
    if (op == 7'h33 || op == 7'h13) begin
      case (f3)
        3'd0: r.val = (op == 7'h33 && f7) ? a - b : a + b;
        3'd1: r.val = a << b[4:0];
        3'd2: begin
          sa = a; sb = b;
          r.val = (sa < sb) ? 32'd1 : 32'd0;
        end
        3'd3: r.val = (a < b) ? 32'd1 : 32'd0;
        3'd4: r.val = a ^ b;
        3'd5: begin
          r.val = a >> b[4:0];
          if (f7 && a[31])
            r.val = r.val | ~(32'hFFFFFFFF >> b[4:0]);
        end
        3'd6: r.val = a | b;
        default: r.val = a & b;
      endcase
    end else if (op == 7'h37) begin
      r.val = imm;
    end else if (op == 7'h17) begin
      r.val = pc + imm;
    end
`ifdef ALU_BRANCH_EN
    else if (op == 7'h63) begin
      sa = a; sb = r2;
      r.target = pc + imm;
      case (f3)
        3'd0: r.jump = a == r2;
        3'd1: r.jump = a != r2;
        3'd4: r.jump = sa < sb;
        3'd5: r.jump = sa >= sb;
        3'd6: r.jump = a < r2;
        3'd7: r.jump = a >= r2;
        default: r.jump = 1'b0;
      endcase
    end else if (op == 7'h6F) begin
      r.val = pc + 4; r.jump = 1'b1; r.target = pc + imm;
    end else if (op == 7'h67) begin
      r.val = pc + 4; r.jump = 1'b1;
      r.target = (a + imm) & 32'hFFFFFFFE;
    end
`endif
    return r;
  endfunction

  task automatic drive(logic en, logic [6:0] op,
                       logic [2:0] f3, logic f7,
                       logic [31:0] v1, logic [31:0] v2,
                       logic [31:0] imm, logic [31:0] pc,
                       logic [3:0] tag);
    bus.alu_en = en;
    bus.alu_opcode = op;
    bus.alu_funct3 = f3;
    bus.alu_funct7 = f7;
    bus.alu_val1 = v1;
    bus.alu_val2 = v2;
    bus.alu_imm = imm;
    bus.alu_pc = pc;
    bus.alu_rob_pos = tag;
  endtask

  task automatic add_issue(logic [3:0] tag, logic [31:0] a);
    drive(1'b1, 7'h33, 3'd0, 1'b0, a, 32'd1, 0, 0, tag);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_clear(string name);
    chk({name, "_rdy"}, bus.alu_rdy, 1);
    chk({name, "_req"}, bus.cdb_req, 0);
    chk({name, "_tag"}, bus.cdb_rob_pos, 0);
    chk({name, "_val"}, bus.cdb_val, 0);
    chk({name, "_jmp"}, bus.cdb_jump, 0);
    chk({name, "_tgt"}, bus.cdb_target, 0);
  endtask

  logic [6:0]  r_op;
  logic [2:0]  r_f3;
  logic [31:0] r_v1;
  logic [31:0] r_v2;
  logic [31:0] r_imm;
  logic [31:0] r_pc;
  logic        r_en;
  logic        fire;
  res_t        e;
  logic [6:0]  ops [8];
  logic [2:0]  bf3 [6];

  initial begin
    ops = '{7'h33, 7'h13, 7'h37, 7'h17,
            7'h63, 7'h6F, 7'h67, 7'h00};
    bf3 = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7};
    drive(1'b0, 0, 0, 0, 0, 0, 0, 0, 0);
    bus.cdb_grant = 1'b0;
    #1;
    chk_clear("reset");
    #20;
    rst_n = 1'b1;
    rdy = 1'b1;
    step();

    // backpressure: fill queue with grant low
    add_issue(4'd1, 32'd1);
    step();
    chk("bp_lat_req", bus.cdb_req, 1);
    chk("bp_lat_tag", bus.cdb_rob_pos, 1);
    chk("bp_rdy1", bus.alu_rdy, 1);
    add_issue(4'd2, 32'd2);
    step();
    bus.alu_en = 1'b0;
    chk("bp_full_rdy", bus.alu_rdy, 0);
    chk("bp_hold_tag", bus.cdb_rob_pos, 1);
    chk("bp_hold_val", bus.cdb_val, 2);
    step();
    chk("bp_hold2_tag", bus.cdb_rob_pos, 1);
    bus.cdb_grant = 1'b1;
    step();
    bus.cdb_grant = 1'b0;
    chk("bp_next_tag", bus.cdb_rob_pos, 2);
    chk("bp_next_val", bus.cdb_val, 3);
    chk("bp_rdy_back", bus.alu_rdy, 1);
    add_issue(4'd5, 32'd9);
    bus.cdb_grant = 1'b1;
    step();
    bus.alu_en = 1'b0;
    bus.cdb_grant = 1'b0;
    chk("sim_req", bus.cdb_req, 1);
    chk("sim_rdy", bus.alu_rdy, 1);
    chk("sim_tag", bus.cdb_rob_pos, 5);
    chk("sim_val", bus.cdb_val, 10);
    bus.cdb_grant = 1'b1;
    step();
    bus.cdb_grant = 1'b0;
    chk("sim_empty", bus.cdb_req, 0);

    // rollback with full queue and an issue pending
    add_issue(4'd6, 32'd0);
    step();
    add_issue(4'd7, 32'd0);
    step();
    chk("rb_full", bus.alu_rdy, 0);
    add_issue(4'd8, 32'd0);
    rollback = 1'b1;
    bus.cdb_grant = 1'b1;
    step();
    rollback = 1'b0;
    bus.alu_en = 1'b0;
    bus.cdb_grant = 1'b0;
    chk("rb_req", bus.cdb_req, 0);
    chk("rb_rdy", bus.alu_rdy, 1);
    step();
    chk("rb_drop", bus.cdb_req, 0);

    // rdy low freezes queue for three cycles
    add_issue(4'd9, 32'd20);
    step();
    add_issue(4'd10, 32'd30);
    bus.cdb_grant = 1'b1;
    rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("frz_req", bus.cdb_req, 1);
      chk("frz_tag", bus.cdb_rob_pos, 9);
      chk("frz_val", bus.cdb_val, 21);
    end
    rdy = 1'b1;
    bus.alu_en = 1'b0;
    step();
    bus.cdb_grant = 1'b0;
    chk("frz_out", bus.cdb_req, 0);

    // asynchronous reset mid-transfer
    add_issue(4'd11, 32'd40);
    step();
    add_issue(4'd12, 32'd50);
    step();
    bus.alu_en = 1'b0;
    #3;
    rst_n = 1'b0;
    #1;
    chk_clear("areset");
    step();
    rst_n = 1'b1;
    step();
    chk("areset_idle", bus.cdb_req, 0);

    // directed vector table
    tbl.push_back(mk(7'h33, 0, 0, 5, 7, 0, 0, 3, 12, 0, 0));
    tbl.push_back(mk(7'h33, 0, 1, 5, 7, 0, 0, 4,
                     32'hFFFFFFFE, 0, 0));
    tbl.push_back(mk(7'h13, 5, 1, 32'h80000000, 0, 32'h404,
                     0, 5, 32'hF8000000, 0, 0));
    tbl.push_back(mk(7'h13, 5, 0, 32'h80000000, 0, 32'h004,
                     0, 6, 32'h08000000, 0, 0));
    tbl.push_back(mk(7'h33, 3, 0, 1, 32'hFFFFFFFF, 0, 0, 7,
                     1, 0, 0));
    tbl.push_back(mk(7'h33, 2, 0, 1, 32'hFFFFFFFF, 0, 0, 8,
                     0, 0, 0));
    tbl.push_back(mk(7'h13, 0, 1, 10, 0, 32'hFFFFFFFF, 0, 9,
                     9, 0, 0));
    tbl.push_back(mk(7'h33, 1, 0, 1, 32'h21, 0, 0, 10,
                     2, 0, 0));
    tbl.push_back(mk(7'h33, 4, 0, 32'hFF00FF00, 32'h0FF00FF0,
                     0, 0, 11, 32'hF0F0F0F0, 0, 0));
    tbl.push_back(mk(7'h33, 6, 0, 32'hF0, 32'h0F, 0, 0, 12,
                     32'hFF, 0, 0));
    tbl.push_back(mk(7'h13, 7, 0, 32'hF0, 0, 32'h3C, 0, 13,
                     32'h30, 0, 0));
    tbl.push_back(mk(7'h37, 0, 0, 0, 0, 32'h12345000, 0, 14,
                     32'h12345000, 0, 0));
    tbl.push_back(mk(7'h17, 0, 0, 0, 0, 32'hFFFFF000,
                     32'h1000, 15, 0, 0, 0));
    tbl.push_back(mk(7'h7F, 0, 0, 3, 4, 5, 6, 2, 0, 0, 0));
`ifdef ALU_BRANCH_EN
    tbl.push_back(mk(7'h63, 4, 0, 32'hFFFFFFFF, 1, 32'h20,
                     32'h100, 1, 0, 1, 32'h120));
    tbl.push_back(mk(7'h67, 0, 0, 32'h203, 0, 0, 32'h40, 3,
                     32'h44, 1, 32'h202));
    tbl.push_back(mk(7'h6F, 0, 0, 0, 0, 32'h100, 32'h40, 4,
                     32'h44, 1, 32'h140));
    tbl.push_back(mk(7'h63, 0, 0, 5, 6, 8, 32'h100, 5,
                     0, 0, 32'h108));
`else
    tbl.push_back(mk(7'h63, 4, 0, 32'hFFFFFFFF, 1, 32'h20,
                     32'h100, 1, 0, 0, 0));
    tbl.push_back(mk(7'h67, 0, 0, 32'h203, 0, 0, 32'h40, 3,
                     0, 0, 0));
    tbl.push_back(mk(7'h6F, 0, 0, 0, 0, 32'h100, 32'h40, 4,
                     0, 0, 0));
`endif
    bus.cdb_grant = 1'b1;
    foreach (tbl[i]) begin
      drive(1'b1, tbl[i].op, tbl[i].f3, tbl[i].f7,
            tbl[i].v1, tbl[i].v2, tbl[i].imm, tbl[i].pc,
            tbl[i].tag);
      step();
      chk($sformatf("vec%0d_req", i), bus.cdb_req, 1);
      chk($sformatf("vec%0d_tag", i), bus.cdb_rob_pos,
          tbl[i].tag);
      chk($sformatf("vec%0d_val", i), bus.cdb_val, tbl[i].ev);
      chk($sformatf("vec%0d_jmp", i), bus.cdb_jump, tbl[i].ej);
      chk($sformatf("vec%0d_tgt", i), bus.cdb_target,
          tbl[i].et);
    end
    bus.alu_en = 1'b0;
    step();
    chk("vec_drain", bus.cdb_req, 0);

    // randomized run against the scoreboard model
    for (int c = 0; c < 3000; c++) begin
      rdy = $urandom_range(0, 9) != 0;
      rollback = $urandom_range(0, 39) == 0;
      r_en = $urandom_range(0, 9) < 7;
      bus.cdb_grant = $urandom_range(0, 9) < 6;
      r_op = ops[$urandom_range(0, 7)];
      r_f3 = 3'($urandom_range(0, 7));
      if (r_op == 7'h63) r_f3 = bf3[$urandom_range(0, 5)];
      r_v1 = ($urandom_range(0, 3) == 0) ?
             32'($urandom_range(0, 8)) : $urandom;
      r_v2 = ($urandom_range(0, 3) == 0) ? r_v1 : $urandom;
      r_imm = $urandom;
      r_pc = $urandom;
      drive(r_en, r_op, r_f3, 1'($urandom_range(0, 1)),
            r_v1, r_v2, r_imm, r_pc,
            4'($urandom_range(0, 15)));
      chk("rnd_rdy", bus.alu_rdy, mq.size() < 2);
      chk("rnd_req", bus.cdb_req, mq.size() > 0);
      if (mq.size() > 0) begin
        chk("rnd_tag", bus.cdb_rob_pos, mq[0].rob_pos);
        chk("rnd_val", bus.cdb_val, mq[0].val);
        chk("rnd_jmp", bus.cdb_jump, mq[0].jump);
        chk("rnd_tgt", bus.cdb_target, mq[0].target);
      end
      fire = rdy && r_en && mq.size() < 2 && !rollback;
      e = model(r_op, r_f3, bus.alu_funct7, r_v1, r_v2,
                r_imm, r_pc);
      e.rob_pos = bus.alu_rob_pos;
      if (rdy) begin
        if (rollback) begin
          mq.delete();
        end else begin
          if (bus.cdb_grant && mq.size() > 0)
            void'(mq.pop_front());
          if (fire) mq.push_back(e);
        end
      end
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
